// File: rtl/router_1xn_pkt.sv
// Single-input, NUM_PORTS-output packet router with per-port first-word-fall-through FIFOs,
// parity/length checking, invalid-destination dropping and per-port read-timeout flush.
module router_1xn_pkt #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          vld_out,
  output logic                          busy,
  output logic                          err,
  output logic                          drop
);

  localparam int DEST_W      = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int LEN_W       = DATA_W - DEST_W;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int TMO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_LAST_I[TMO_W-1:0];
  localparam logic [AW:0]      DEPTH_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DROP,
    CHECK
  } state_t;

  state_t state, state_nxt;

  logic [DEST_W-1:0]    dest_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     pay_cnt_q;
  logic [DATA_W-1:0]    parity_q;
  logic                 bad_q;
  logic                 drop_q;

  logic [DEST_W-1:0]    hdr_dest;
  logic [DEST_W-1:0]    dest_sel;
  logic                 hdr_ok;
  logic                 tgt_full;
  logic                 accept;
  logic                 do_write;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] flush;
  logic [NUM_PORTS-1:0] wr_en;

  assign hdr_dest = data_in[DEST_W-1:0];
  assign hdr_ok   = (int'(hdr_dest) < NUM_PORTS);
  // In IDLE the byte on data_in is the header, so its dest field selects the FIFO directly.
  assign dest_sel = (state == IDLE) ? hdr_dest : dest_q;

  always_comb begin
    tgt_full = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (dest_sel == DEST_W'(p)) tgt_full = full[p];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_valid) begin
          if (!hdr_ok) begin
            accept    = 1'b1;
            state_nxt = DROP;
          end else if (tgt_full) begin
            busy = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (tgt_full) begin
          busy = 1'b1;
        end else begin
          accept = 1'b1;
          if (!pkt_valid) state_nxt = CHECK;
        end
      end
      DROP: begin
        accept = 1'b1;
        if (!pkt_valid) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign do_write = accept && ((state == IDLE && hdr_ok) || state == LOAD);
  assign err      = (state == CHECK) && !drop_q && bad_q;
  assign drop     = (state == CHECK) && drop_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      pay_cnt_q <= '0;
      parity_q  <= '0;
      bad_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (state == IDLE) begin
          dest_q    <= hdr_dest;
          len_q     <= data_in[DATA_W-1:DEST_W];
          pay_cnt_q <= '0;
          parity_q  <= data_in;
          bad_q     <= 1'b0;
          drop_q    <= !hdr_ok;
        end else if (pkt_valid) begin
          pay_cnt_q <= pay_cnt_q + LEN_W'(1);
          parity_q  <= parity_q ^ data_in;
        end else begin
          // Length compares modulo 2^LEN_W because pay_cnt_q wraps at that width.
          bad_q <= (data_in != parity_q) || (pay_cnt_q != len_q);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int PI = p;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       count;
    logic [TMO_W-1:0]  tmo_cnt;

    assign count       = wr_ptr - rd_ptr;
    assign full[p]     = (count == DEPTH_CNT);
    assign vld_out[p]  = (count != '0);
    assign pop[p]      = read_enb[p] && vld_out[p];
    assign flush[p]    = (TIMEOUT > 0) && vld_out[p] && !read_enb[p] && (tmo_cnt == TMO_LAST);
    // A flush on the same edge as a write wins; the byte is deliberately lost.
    assign wr_en[p]    = do_write && (dest_sel == PI[DEST_W-1:0]) && !flush[p];
    assign data_out[p*DATA_W +: DATA_W] = vld_out[p] ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        tmo_cnt <= '0;
      end else begin
        if (flush[p]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (wr_en[p]) wr_ptr <= wr_ptr + (AW+1)'(1);
          if (pop[p])   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
        if (flush[p] || !vld_out[p] || read_enb[p] || TIMEOUT == 0) tmo_cnt <= '0;
        else                                                      tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end

    // NOTE: the storage array is not reset; pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
      if (wr_en[p]) mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_router_1xn_pkt.sv
// Self-checking bench for router_1xn_pkt: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a queue-based packet model.
module tb_router_1xn_pkt;

  localparam int NP      = 3;
  localparam int DEPTH   = 16;
  localparam int TMO     = 30;

  logic        clock;
  logic        reset;

  logic        pv;
  logic [7:0]  din;
  logic [2:0]  rd;
  logic [23:0] dout;
  logic [2:0]  vld;
  logic        busy, err, drop;

  logic        pv_s;
  logic [7:0]  din_s;
  logic [2:0]  rd_s;
  logic [23:0] dout_s;
  logic [2:0]  vld_s;
  logic        busy_s, err_s, drop_s;

  int n_checks = 0;
  int n_fail   = 0;

  router_1xn_pkt dut (
    .clock     (clock),
    .reset     (reset),
    .pkt_valid (pv),
    .data_in   (din),
    .read_enb  (rd),
    .data_out  (dout),
    .vld_out   (vld),
    .busy      (busy),
    .err       (err),
    .drop      (drop)
  );

  router_1xn_pkt #(.FIFO_DEPTH(4), .TIMEOUT(0)) dut_s (
    .clock     (clock),
    .reset     (reset),
    .pkt_valid (pv_s),
    .data_in   (din_s),
    .read_enb  (rd_s),
    .data_out  (dout_s),
    .vld_out   (vld_s),
    .busy      (busy_s),
    .err       (err_s),
    .drop      (drop_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        pv;
    logic [7:0]  din;
    logic [2:0]  rd;
    logic [2:0]  vld;
    logic        busy;
    logic        err;
    logic        drop;
    logic [23:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic p, input logic [7:0] d, input logic [2:0] re,
                              input logic [2:0] v, input logic b, input logic e, input logic dr,
                              input logic [23:0] o);
    vecs.push_back('{rst: r, pv: p, din: d, rd: re, vld: v, busy: b, err: e, drop: dr, dout: o});
  endfunction

  // Reference model state for the randomized phase.
  typedef struct {
    logic       pv;
    logic [7:0] b;
  } item_t;

  item_t      items[$];
  logic [7:0] mq [NP][$];
  int         tmo_m [NP];
  logic [1:0] cur_dest;
  logic       cur_drop, cur_bad, in_check;
  int         gap;

  task automatic gen_packet();
    int         n;
    logic [5:0] len;
    logic [7:0] hdr, par, b;
    n        = int'($urandom_range(0, 20));
    cur_dest = 2'($urandom_range(0, 3));
    cur_drop = (cur_dest == 2'd3);
    len      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(n);
    hdr      = {len, cur_dest};
    par      = hdr;
    items.push_back('{pv: 1'b1, b: hdr});
    for (int i = 0; i < n; i++) begin
      b   = 8'($urandom);
      par = par ^ b;
      items.push_back('{pv: 1'b1, b: b});
    end
    cur_bad = (len != 6'(n));
    if ($urandom_range(0, 4) == 0) begin
      par     = par ^ 8'(1 << $urandom_range(0, 7));
      cur_bad = 1'b1;
    end
    items.push_back('{pv: 1'b0, b: par});
  endtask

  task automatic step_s(input string name, input logic p, input logic [7:0] d, input logic r,
                        input logic exp_busy, input logic exp_vld0, input logic [7:0] exp_d0);
    @(negedge clock);
    pv_s  = p;
    din_s = d;
    rd_s  = {2'b00, r};
    #1;
    check({name, "_busy"}, 32'(busy_s), 32'(exp_busy));
    check({name, "_vld0"}, 32'(vld_s[0]), 32'(exp_vld0));
    check({name, "_dout0"}, 32'(dout_s[7:0]), 32'(exp_d0));
  endtask

  initial begin
    logic        exp_busy, acc, nxt_check;
    logic [23:0] exp_dout;
    logic [2:0]  exp_vld;
    logic        fl [4];
    item_t       it;
    int          rprob;

    reset = 1'b1;
    pv = 1'b0; din = 8'h00; rd = 3'b000;
    pv_s = 1'b0; din_s = 8'h00; rd_s = 3'b000;

    // rst pv din rd | vld busy err drop dout
    add(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    // Port 0: 04,11,15 then three pops
    add(0, 1, 8'h04, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    add(0, 1, 8'h11, 3'b000, 3'b001, 0, 0, 0, 24'h000004);
    add(0, 0, 8'h15, 3'b000, 3'b001, 0, 0, 0, 24'h000004);
    add(0, 0, 8'h00, 3'b000, 3'b001, 1, 0, 0, 24'h000004);
    add(0, 0, 8'h00, 3'b001, 3'b001, 0, 0, 0, 24'h000004);
    add(0, 0, 8'h00, 3'b001, 3'b001, 0, 0, 0, 24'h000011);
    add(0, 0, 8'h00, 3'b001, 3'b001, 0, 0, 0, 24'h000015);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    // Port 2: header 0E, payload 33 44 55, correct parity 0x2C
    add(0, 1, 8'h0E, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    add(0, 1, 8'h33, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 1, 8'h44, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 1, 8'h55, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 0, 8'h2C, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 0, 8'h00, 3'b000, 3'b100, 1, 0, 0, 24'h0E0000);
    // Same packet with parity 00: err for exactly the CHECK cycle
    add(0, 1, 8'h0E, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 1, 8'h33, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 1, 8'h44, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 1, 8'h55, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 0, 8'h00, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(0, 0, 8'h00, 3'b000, 3'b100, 1, 1, 0, 24'h0E0000);
    add(0, 0, 8'h00, 3'b000, 3'b100, 0, 0, 0, 24'h0E0000);
    add(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    // Port 1: len=2 but one payload byte -> length error
    add(0, 1, 8'h09, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    add(0, 1, 8'h22, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    add(0, 0, 8'h2B, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    add(0, 0, 8'h00, 3'b000, 3'b010, 1, 1, 0, 24'h000900);
    add(0, 0, 8'h00, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    // Invalid destination 3: nothing written, drop pulse, busy only in CHECK
    add(0, 1, 8'h07, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    add(0, 1, 8'hAA, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    add(0, 0, 8'hAD, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    add(0, 0, 8'h00, 3'b000, 3'b010, 1, 0, 1, 24'h000900);
    add(0, 0, 8'h00, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    // Reset mid-packet, then a clean packet to port 1
    add(0, 1, 8'h04, 3'b000, 3'b010, 0, 0, 0, 24'h000900);
    add(0, 1, 8'h11, 3'b000, 3'b011, 0, 0, 0, 24'h000904);
    add(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    add(0, 1, 8'h05, 3'b000, 3'b000, 0, 0, 0, 24'h000000);
    add(0, 1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 24'h000500);
    add(0, 0, 8'h14, 3'b000, 3'b010, 0, 0, 0, 24'h000500);
    add(0, 0, 8'h00, 3'b000, 3'b010, 1, 0, 0, 24'h000500);
    add(0, 0, 8'h00, 3'b000, 3'b010, 0, 0, 0, 24'h000500);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst;
      pv    = vecs[i].pv;
      din   = vecs[i].din;
      rd    = vecs[i].rd;
      #1;
      check($sformatf("row%0d_vld", i),  32'(vld),  32'(vecs[i].vld));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("row%0d_err", i),  32'(err),  32'(vecs[i].err));
      check($sformatf("row%0d_drop", i), 32'(drop), 32'(vecs[i].drop));
      check($sformatf("row%0d_dout", i), 32'(dout), 32'(vecs[i].dout));
    end

    // Depth-4 instance: 6-byte packet to port 0 stalls when full, resumes after two pops.
    step_s("s0",  1, 8'h10, 0, 0, 0, 8'h00);
    step_s("s1",  1, 8'h01, 0, 0, 1, 8'h10);
    step_s("s2",  1, 8'h02, 0, 0, 1, 8'h10);
    step_s("s3",  1, 8'h03, 0, 0, 1, 8'h10);
    step_s("s4",  1, 8'h04, 0, 1, 1, 8'h10);
    step_s("s5",  1, 8'h04, 0, 1, 1, 8'h10);
    step_s("s6",  1, 8'h04, 1, 1, 1, 8'h10);
    step_s("s7",  1, 8'h04, 1, 0, 1, 8'h01);
    step_s("s8",  0, 8'h14, 0, 0, 1, 8'h02);
    step_s("s9",  0, 8'h00, 0, 1, 1, 8'h02);
    check("s9_err", 32'(err_s), 32'(0));
    step_s("s10", 0, 8'h00, 1, 0, 1, 8'h02);
    step_s("s11", 0, 8'h00, 1, 0, 1, 8'h03);
    step_s("s12", 0, 8'h00, 1, 0, 1, 8'h04);
    step_s("s13", 0, 8'h00, 1, 0, 1, 8'h14);
    step_s("s14", 0, 8'h00, 0, 0, 0, 8'h00);

    // Timeout: port 1 holds data unread; vld_out[1] survives 30 unread cycles, gone on the 31st.
    @(negedge clock);
    reset = 1'b1; pv = 1'b0; rd = 3'b000;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clock);
      pv  = (k < 2);
      din = (k == 0) ? 8'h05 : (k == 1) ? 8'h11 : (k == 2) ? 8'h14 : 8'h00;
      #1;
      if (k == 30) check("tmo_hold", 32'(vld[1]), 32'(1));
      if (k == 31) begin
        check("tmo_flush", 32'(vld[1]), 32'(0));
        check("tmo_dout", 32'(dout[15:8]), 32'(0));
        check("tmo_busy", 32'(busy), 32'(0));
      end
    end

    // Randomized traffic against the queue model.
    @(negedge clock);
    reset = 1'b1; pv = 1'b0; rd = 3'b000;
    @(negedge clock);
    reset = 1'b0;
    items.delete();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      tmo_m[p] = 0;
    end
    in_check = 1'b0; cur_drop = 1'b0; cur_bad = 1'b0; cur_dest = 2'd0; gap = 0; rprob = 100;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (cyc % 150 == 0) begin
        case ($urandom_range(0, 3))
          0:       rprob = 0;
          1:       rprob = 25;
          2:       rprob = 70;
          default: rprob = 100;
        endcase
      end
      if (!in_check && items.size() == 0) begin
        if (gap > 0) gap--;
        else         gen_packet();
      end
      if (items.size() > 0) begin
        pv  = items[0].pv;
        din = items[0].b;
      end else begin
        pv  = 1'b0;
        din = 8'($urandom);
      end
      for (int p = 0; p < NP; p++) rd[p] = ($urandom_range(0, 99) < rprob);
      #1;

      exp_busy = in_check || (items.size() > 0 && !cur_drop && mq[cur_dest].size() == DEPTH);
      for (int p = 0; p < NP; p++) begin
        exp_vld[p]        = (mq[p].size() > 0);
        exp_dout[p*8 +: 8] = (mq[p].size() > 0) ? mq[p][0] : 8'h00;
      end
      check($sformatf("rnd%0d_vld", cyc),  32'(vld),  32'(exp_vld));
      check($sformatf("rnd%0d_dout", cyc), 32'(dout), 32'(exp_dout));
      check($sformatf("rnd%0d_busy", cyc), 32'(busy), 32'(exp_busy));
      check($sformatf("rnd%0d_err", cyc),  32'(err),  32'(in_check && !cur_drop && cur_bad));
      check($sformatf("rnd%0d_drop", cyc), 32'(drop), 32'(in_check && cur_drop));

      // Effects of the coming edge: timeouts, pops, then the accepted byte.
      fl[3] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        fl[p] = 1'b0;
        if (mq[p].size() > 0 && !rd[p]) begin
          tmo_m[p]++;
          if (tmo_m[p] == TMO) begin
            fl[p]    = 1'b1;
            tmo_m[p] = 0;
          end
        end else begin
          tmo_m[p] = 0;
        end
        if (fl[p])                          mq[p].delete();
        else if (rd[p] && mq[p].size() > 0) void'(mq[p].pop_front());
      end
      acc       = (items.size() > 0) && !exp_busy;
      nxt_check = 1'b0;
      if (acc) begin
        it = items.pop_front();
        if (!cur_drop && !fl[cur_dest]) mq[cur_dest].push_back(it.b);
        if (!it.pv) nxt_check = 1'b1;
      end
      if (in_check) gap = int'($urandom_range(0, 3));
      in_check = nxt_check;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
